// File: rtl/muldiv_unit.sv
// muldiv_unit -- iterative RV32M multiply/divide unit.
//
// One operation at a time: accepted in IDLE, 32 single-bit iterations in CALC
// (shift-add multiply / restoring divide on operand magnitudes), then the
// sign-corrected result is held in DONE until the consumer takes it.
//
// Optional build macro: MULDIV_FASTPATH_EN
//   When defined, divide by zero, signed divide overflow and multiplies with a
//   zero operand skip CALC and go straight from IDLE to DONE.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid / in_ready   request handshake (in_ready high only in IDLE)
//   op                    RV32M funct3 (MUL..REMU)
//   a, b                  rs1 / rs2 operands
//   flush                 abort whatever is in flight, back to IDLE
//   out_valid / out_ready result handshake
//   result                registered result, stable while out_valid is high
//   busy                  high in CALC or DONE
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

    state_e               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [2:0]           op_q, op_d;
    logic                 sa_q, sa_d;     // operand a was negative and signed
    logic                 sb_q, sb_d;     // operand b was negative and signed
    logic                 bz_q, bz_d;     // divisor is zero
    logic [WIDTH-1:0]     opnd_q, opnd_d; // multiplicand (mul) or divisor (div) magnitude
    logic [2*WIDTH-1:0]   acc_q, acc_d;   // {partial/remainder, multiplier/quotient}
    logic [WIDTH-1:0]     result_q, result_d;

    // ---------------- request decode ----------------
    logic             a_sgn, b_sgn, sa_in, sb_in;
    logic [WIDTH-1:0] ma, mb;

    always_comb begin
        if (op[2]) begin
            a_sgn = ~op[0];             // DIV/REM signed, DIVU/REMU unsigned
            b_sgn = ~op[0];
        end else begin
            a_sgn = (op[1:0] != 2'b11); // MUL, MULH, MULHSU treat a as signed
            b_sgn = ~op[1];             // only MUL, MULH treat b as signed
        end
        sa_in = a_sgn & a[WIDTH-1];
        sb_in = b_sgn & b[WIDTH-1];
        ma    = sa_in ? -a : a;
        mb    = sb_in ? -b : b;
    end

    // ---------------- one iteration ----------------
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_sh;
    logic [WIDTH-1:0]   div_diff;
    logic [2*WIDTH-1:0] acc_step;

    always_comb begin
        // Multiply: add multiplicand into the high half when the multiplier
        // LSB is set, then shift the whole accumulator right by one.
        mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        // Divide: shift the next dividend bit into the remainder and try to
        // subtract. The true difference always fits in WIDTH bits when it is
        // non-negative, since the remainder stays below the divisor.
        div_sh   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        div_diff = div_sh[WIDTH-1:0] - opnd_q;
        if (op_q[2]) begin
            if (div_sh >= {1'b0, opnd_q})
                acc_step = {div_diff, acc_q[WIDTH-2:0], 1'b1};
            else
                acc_step = {div_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
        end else begin
            acc_step = {mul_sum, acc_q[WIDTH-1:1]};
        end
    end

    // ---------------- sign correction of the final iteration ----------------
    logic [2*WIDTH-1:0] prod_s;
    logic [WIDTH-1:0]   quo_s, rem_s, fin_res;

    always_comb begin
        prod_s = (sa_q ^ sb_q) ? -acc_step : acc_step;
        quo_s  = (sa_q ^ sb_q) ? -acc_step[WIDTH-1:0] : acc_step[WIDTH-1:0];
        rem_s  = sa_q ? -acc_step[2*WIDTH-1:WIDTH] : acc_step[2*WIDTH-1:WIDTH];
        if (op_q[2]) begin
            // The remainder already comes out as a on a zero divisor; only the
            // signed quotient needs forcing to all-ones.
            if (op_q[1])   fin_res = rem_s;
            else if (bz_q) fin_res = '1;
            else           fin_res = quo_s;
        end else begin
            fin_res = (op_q[1:0] == 2'b00) ? prod_s[WIDTH-1:0] : prod_s[2*WIDTH-1:WIDTH];
        end
    end

    // ---------------- zero-iteration special cases ----------------
    logic             fast;
    logic [WIDTH-1:0] fast_res;

`ifdef MULDIV_FASTPATH_EN
    always_comb begin
        fast     = 1'b0;
        fast_res = '0;
        if (op[2]) begin
            if (b == '0) begin
                fast     = 1'b1;
                fast_res = op[1] ? a : '1;
            end else if (!op[0] && a == {1'b1, {(WIDTH-1){1'b0}}} && b == '1) begin
                fast     = 1'b1;
                fast_res = op[1] ? '0 : a;
            end
        end else if (a == '0 || b == '0) begin
            fast = 1'b1;
        end
    end
`else
    assign fast     = 1'b0;
    assign fast_res = '0;
`endif

    // ---------------- FSM ----------------
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        sa_d     = sa_q;
        sb_d     = sb_q;
        bz_d     = bz_q;
        opnd_d   = opnd_q;
        acc_d    = acc_q;
        result_d = result_q;
        if (flush) begin
            // Flush beats accept and out_ready; nothing is sampled on this edge.
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        op_d   = op;
                        sa_d   = sa_in;
                        sb_d   = sb_in;
                        bz_d   = (b == '0);
                        opnd_d = op[2] ? mb : ma;
                        acc_d  = {{WIDTH{1'b0}}, (op[2] ? ma : mb)};
                        cnt_d  = '0;
                        if (fast) begin
                            state_d  = DONE;
                            result_d = fast_res;
                        end else begin
                            state_d  = CALC;
                        end
                    end
                end
                CALC: begin
                    acc_d = acc_step;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CW'(WIDTH-1)) begin
                        state_d  = DONE;
                        cnt_d    = '0;
                        result_d = fin_res;
                    end
                end
                DONE: begin
                    if (out_ready) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            op_q     <= '0;
            sa_q     <= 1'b0;
            sb_q     <= 1'b0;
            bz_q     <= 1'b0;
            opnd_q   <= '0;
            acc_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            sa_q     <= sa_d;
            sb_q     <= sb_d;
            bz_q     <= bz_d;
            opnd_q   <= opnd_d;
            acc_q    <= acc_d;
            result_q <= result_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign out_valid = (state_q == DONE);
    assign result    = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed testbench for muldiv_unit: hand-computed RV32M results, latency,
// back-pressure, flush and mid-operation reset behaviour.
module tb_muldiv_unit;

    localparam logic [2:0] OP_MUL = 3'b000, OP_MULH = 3'b001, OP_MULHSU = 3'b010,
                           OP_MULHU = 3'b011, OP_DIV = 3'b100, OP_DIVU = 3'b101,
                           OP_REM = 3'b110, OP_REMU = 3'b111;

`ifdef MULDIV_FASTPATH_EN
    localparam int SPECIAL_LAT = 1;
`else
    localparam int SPECIAL_LAT = 33;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  op = 3'b000;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        flush = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] result;
    logic        busy;

    int pass_cnt = 0;
    int total_cnt = 0;

    muldiv_unit #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .a(a), .b(b), .flush(flush), .out_valid(out_valid),
        .out_ready(out_ready), .result(result), .busy(busy)
    );

    always #5 clk = ~clk;

    // Issue one request, then measure cycles from accept to first out_valid
    // and consume the result. Operands are scrambled after the accept edge.
    task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                          output logic [31:0] res, output int lat);
        @(negedge clk);
        op = o; a = x; b = y; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; op = ~o; a = 32'hDEADBEEF; b = 32'h5A5A5A5A;
        lat = 1;
        while (!out_valid && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        res = result;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        total_cnt++;
        if ({in_ready, out_valid, busy, result} !== {1'b1, 1'b0, 1'b0, 32'h0})
            $display("FAIL reset_state: got rdy=%b vld=%b busy=%b res=%h expected 1 0 0 00000000",
                     in_ready, out_valid, busy, result);
        else pass_cnt++;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        total_cnt++;
        if (in_ready !== 1'b1) $display("FAIL reset_release_ready: got %b expected 1", in_ready);
        else pass_cnt++;
    endtask

    task automatic test_mul();
        logic [31:0] r;
        int lat;
        run_op(OP_MUL, 32'd7, 32'd6, r, lat);
        total_cnt++;
        if (r !== 32'h0000002A) $display("FAIL mul_7x6: got %h expected 0000002a", r);
        else pass_cnt++;
        total_cnt++;
        if (lat !== 33) $display("FAIL mul_latency: got %0d expected 33", lat);
        else pass_cnt++;
        run_op(OP_MUL, 32'h12345678, 32'h10, r, lat);
        total_cnt++;
        if (r !== 32'h23456780) $display("FAIL mul_shift: got %h expected 23456780", r);
        else pass_cnt++;
        run_op(OP_MUL, 32'hFFFFFFFD, 32'd5, r, lat);
        total_cnt++;
        if (r !== 32'hFFFFFFF1) $display("FAIL mul_neg: got %h expected fffffff1", r);
        else pass_cnt++;
        run_op(OP_MUL, 32'h0, 32'd5, r, lat);
        total_cnt++;
        if (r !== 32'h0 || lat !== SPECIAL_LAT)
            $display("FAIL mul_zero: got %h lat %0d expected 00000000 lat %0d", r, lat, SPECIAL_LAT);
        else pass_cnt++;
    endtask

    task automatic test_mul_high();
        logic [31:0] r;
        int lat;
        run_op(OP_MULH, 32'hFFFFFFFF, 32'hFFFFFFFF, r, lat);
        total_cnt++;
        if (r !== 32'h00000000) $display("FAIL mulh_m1: got %h expected 00000000", r);
        else pass_cnt++;
        run_op(OP_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, r, lat);
        total_cnt++;
        if (r !== 32'hFFFFFFFE) $display("FAIL mulhu_max: got %h expected fffffffe", r);
        else pass_cnt++;
        run_op(OP_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, r, lat);
        total_cnt++;
        if (r !== 32'hFFFFFFFF) $display("FAIL mulhsu_m1: got %h expected ffffffff", r);
        else pass_cnt++;
        run_op(OP_MULHU, 32'h80000000, 32'd2, r, lat);
        total_cnt++;
        if (r !== 32'h00000001) $display("FAIL mulhu_carry: got %h expected 00000001", r);
        else pass_cnt++;
    endtask

    task automatic test_div();
        logic [31:0] r;
        int lat;
        run_op(OP_DIV, 32'hFFFFFFF9, 32'd2, r, lat);
        total_cnt++;
        if (r !== 32'hFFFFFFFD) $display("FAIL div_m7_2: got %h expected fffffffd", r);
        else pass_cnt++;
        run_op(OP_REM, 32'hFFFFFFF9, 32'd2, r, lat);
        total_cnt++;
        if (r !== 32'hFFFFFFFF) $display("FAIL rem_m7_2: got %h expected ffffffff", r);
        else pass_cnt++;
        run_op(OP_DIV, 32'd7, 32'hFFFFFFFE, r, lat);
        total_cnt++;
        if (r !== 32'hFFFFFFFD) $display("FAIL div_7_m2: got %h expected fffffffd", r);
        else pass_cnt++;
        run_op(OP_REM, 32'd7, 32'hFFFFFFFE, r, lat);
        total_cnt++;
        if (r !== 32'h00000001) $display("FAIL rem_7_m2: got %h expected 00000001", r);
        else pass_cnt++;
        run_op(OP_DIVU, 32'd100, 32'd7, r, lat);
        total_cnt++;
        if (r !== 32'd14 || lat !== 33) $display("FAIL divu_100_7: got %h lat %0d expected 0000000e lat 33", r, lat);
        else pass_cnt++;
        run_op(OP_REMU, 32'd100, 32'd7, r, lat);
        total_cnt++;
        if (r !== 32'd2) $display("FAIL remu_100_7: got %h expected 00000002", r);
        else pass_cnt++;
        run_op(OP_DIVU, 32'd7, 32'd0, r, lat);
        total_cnt++;
        if (r !== 32'hFFFFFFFF || lat !== SPECIAL_LAT)
            $display("FAIL divu_by0: got %h lat %0d expected ffffffff lat %0d", r, lat, SPECIAL_LAT);
        else pass_cnt++;
        run_op(OP_REMU, 32'd7, 32'd0, r, lat);
        total_cnt++;
        if (r !== 32'd7 || lat !== SPECIAL_LAT)
            $display("FAIL remu_by0: got %h lat %0d expected 00000007 lat %0d", r, lat, SPECIAL_LAT);
        else pass_cnt++;
        run_op(OP_DIV, 32'hFFFFFFF9, 32'd0, r, lat);
        total_cnt++;
        if (r !== 32'hFFFFFFFF) $display("FAIL div_neg_by0: got %h expected ffffffff", r);
        else pass_cnt++;
        run_op(OP_REM, 32'hFFFFFFF9, 32'd0, r, lat);
        total_cnt++;
        if (r !== 32'hFFFFFFF9) $display("FAIL rem_neg_by0: got %h expected fffffff9", r);
        else pass_cnt++;
    endtask

    task automatic test_overflow();
        logic [31:0] r;
        int lat;
        run_op(OP_DIV, 32'h80000000, 32'hFFFFFFFF, r, lat);
        total_cnt++;
        if (r !== 32'h80000000 || lat !== SPECIAL_LAT)
            $display("FAIL div_ovf: got %h lat %0d expected 80000000 lat %0d", r, lat, SPECIAL_LAT);
        else pass_cnt++;
        run_op(OP_REM, 32'h80000000, 32'hFFFFFFFF, r, lat);
        total_cnt++;
        if (r !== 32'h0 || lat !== SPECIAL_LAT)
            $display("FAIL rem_ovf: got %h lat %0d expected 00000000 lat %0d", r, lat, SPECIAL_LAT);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        int cyc;
        int seen;
        @(negedge clk);
        op = OP_MUL; a = 32'd3; b = 32'd5; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; a = '0; b = '0;
        total_cnt++;
        if ({busy, in_ready} !== 2'b10) $display("FAIL calc_busy: got busy=%b rdy=%b expected 1 0", busy, in_ready);
        else pass_cnt++;
        repeat (5) @(negedge clk);
        op = OP_DIVU; a = 32'd100; b = 32'd7; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        cyc = 0;
        while (!out_valid && cyc < 60) begin
            @(negedge clk);
            cyc++;
        end
        total_cnt++;
        if (out_valid !== 1'b1) $display("FAIL bp_done_timeout: got out_valid %b expected 1", out_valid);
        else pass_cnt++;
        for (int i = 0; i < 10; i++) begin
            total_cnt++;
            if ({out_valid, in_ready, result} !== {1'b1, 1'b0, 32'd15})
                $display("FAIL bp_hold_%0d: got vld=%b rdy=%b res=%h expected 1 0 0000000f",
                         i, out_valid, in_ready, result);
            else pass_cnt++;
            @(negedge clk);
        end
        out_ready = 1'b1;
        #1;
        total_cnt++;
        if (in_ready !== 1'b0) $display("FAIL bp_ready_same_cycle: got %b expected 0", in_ready);
        else pass_cnt++;
        @(negedge clk);
        out_ready = 1'b0;
        total_cnt++;
        if ({in_ready, out_valid} !== 2'b10) $display("FAIL bp_release: got rdy=%b vld=%b expected 1 0", in_ready, out_valid);
        else pass_cnt++;
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        total_cnt++;
        if (seen !== 0) $display("FAIL calc_in_valid_ignored: got %0d valid cycles expected 0", seen);
        else pass_cnt++;
    endtask

    task automatic test_flush();
        int seen;
        @(negedge clk);
        op = OP_DIVU; a = 32'd100; b = 32'd7; in_valid = 1'b1;
        @(negedge clk);          // counter = 0 in this cycle
        in_valid = 1'b0;
        repeat (15) @(negedge clk); // counter = 15
        flush = 1'b1;
        @(negedge clk);
        total_cnt++;
        if ({in_ready, busy, out_valid} !== 3'b100)
            $display("FAIL flush_idle: got rdy=%b busy=%b vld=%b expected 1 0 0", in_ready, busy, out_valid);
        else pass_cnt++;
        op = OP_MUL; a = 32'd7; b = 32'd6; in_valid = 1'b1;
        @(negedge clk);
        total_cnt++;
        if ({in_ready, busy} !== 2'b10) $display("FAIL flush_beats_accept: got rdy=%b busy=%b expected 1 0", in_ready, busy);
        else pass_cnt++;
        flush = 1'b0; in_valid = 1'b0;
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        total_cnt++;
        if (seen !== 0) $display("FAIL flush_no_result: got %0d valid cycles expected 0", seen);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid_calc();
        logic [31:0] r;
        int lat;
        int seen;
        run_op(OP_MUL, 32'd7, 32'd6, r, lat);
        total_cnt++;
        if (r !== 32'h2A) $display("FAIL pre_reset_mul: got %h expected 0000002a", r);
        else pass_cnt++;
        @(negedge clk);
        op = OP_MUL; a = 32'd3; b = 32'd5; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        #1;
        total_cnt++;
        if ({in_ready, out_valid, busy, result} !== {1'b1, 1'b0, 1'b0, 32'h0})
            $display("FAIL reset_mid_calc: got rdy=%b vld=%b busy=%b res=%h expected 1 0 0 00000000",
                     in_ready, out_valid, busy, result);
        else pass_cnt++;
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        total_cnt++;
        if (seen !== 0 || in_ready !== 1'b1)
            $display("FAIL reset_discard: got %0d valid cycles rdy=%b expected 0 1", seen, in_ready);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_mul();
        test_mul_high();
        test_div();
        test_overflow();
        test_back_to_back();
        test_flush();
        test_reset_mid_calc();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
